ts_readout_arbiter: RTL and testbench

TS_READOUT_ARBITER -- requirements
Module: ts_readout_arbiter

---
 rtl/ts_readout_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ts_readout_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_readout_arbiter.sv
// Merges two first-word-fall-through timestamp FIFOs into one output register, locking onto a source between packet head and tail.
// Optional protocol error counter is built only when TS_ARB_ERR_CNT_EN is defined.
module ts_readout_arbiter #(
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic        BUS_CLK,
    input  logic        RST,
    input  logic        IN0_EMPTY,
    input  logic [31:0] IN0_DATA,
    output logic        IN0_READ,
    input  logic        IN1_EMPTY,
    input  logic [31:0] IN1_DATA,
    output logic        IN1_READ,
    input  logic        OUT_READ,
    output logic        OUT_EMPTY,
    output logic [31:0] OUT_DATA,
    output logic [1:0]  LOCKED,
    output logic [7:0]  ERR_CNT
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_t;

    localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] outData_q, outData_d;
    logic        outEmpty_q, outEmpty_d;
    logic [15:0] idleCnt_q, idleCnt_d;
    logic        lastSrc_q, lastSrc_d;

    logic        loadable;
    logic        selSrc;
    logic        selValid;
    logic        pop;
    logic [31:0] popWord;
    logic        popIsHead;
    logic        lockIdle;
    logic        timeoutHit;

    // Source choice: a lock pins the source, otherwise round-robin against the last one served.
    always_comb begin
        selSrc   = 1'b0;
        selValid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!IN0_EMPTY && !IN1_EMPTY) begin
                    selSrc   = ~lastSrc_q;
                    selValid = 1'b1;
                end else if (!IN0_EMPTY) begin
                    selValid = 1'b1;
                end else if (!IN1_EMPTY) begin
                    selSrc   = 1'b1;
                    selValid = 1'b1;
                end
            end
            LOCK0: selValid = ~IN0_EMPTY;
            LOCK1: begin
                selSrc   = 1'b1;
                selValid = ~IN1_EMPTY;
            end
            default: ;
        endcase
    end

    assign loadable   = outEmpty_q | OUT_READ;
    assign pop        = selValid & loadable & ~RST;
    assign IN0_READ   = pop & ~selSrc;
    assign IN1_READ   = pop & selSrc;
    assign popWord    = selSrc ? IN1_DATA : IN0_DATA;
    assign popIsHead  = (popWord[27:24] == 4'h1);
    // A stalled output register must not age the lock, hence the loadable term.
    assign lockIdle   = (state_q != IDLE) & ~selValid & loadable;
    assign timeoutHit = lockIdle & (idleCnt_q == TimeoutLast);

    always_comb begin
        state_d   = state_q;
        lastSrc_d = lastSrc_q;
        idleCnt_d = idleCnt_q;
        LOCKED    = 2'b00;
        case (state_q)
            IDLE: begin
                idleCnt_d = 16'd0;
                if (pop) begin
                    lastSrc_d = selSrc;
                    if (popIsHead) begin
                        state_d = selSrc ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0, LOCK1: begin
                LOCKED = (state_q == LOCK0) ? 2'b01 : 2'b10;
                if (pop) begin
                    idleCnt_d = 16'd0;
                    lastSrc_d = selSrc;
                    if (!popIsHead) begin
                        state_d = IDLE;
                    end
                end else if (timeoutHit) begin
                    idleCnt_d = 16'd0;
                    state_d   = IDLE;
                end else if (lockIdle) begin
                    idleCnt_d = idleCnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outData_d  = outData_q;
        outEmpty_d = outEmpty_q;
        if (pop) begin
            outData_d  = popWord;
            outEmpty_d = 1'b0;
        end else if (OUT_READ) begin
            outEmpty_d = 1'b1;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            outData_q  <= 32'd0;
            outEmpty_q <= 1'b1;
            idleCnt_q  <= 16'd0;
            lastSrc_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            outData_q  <= outData_d;
            outEmpty_q <= outEmpty_d;
            idleCnt_q  <= idleCnt_d;
            lastSrc_q  <= lastSrc_d;
        end
    end

    assign OUT_DATA  = outData_q;
    assign OUT_EMPTY = outEmpty_q;

`ifdef TS_ARB_ERR_CNT_EN
    logic       popIsTail;
    logic       errEvent;
    logic [7:0] errCnt_q, errCnt_d;

    assign popIsTail = (popWord[27:24] == 4'h2);

    // Orphan head, bad type and timeout are exclusive per cycle but are OR-ed so one cycle never counts twice.
    always_comb begin
        errEvent = (state_q != IDLE) && ((pop && !popIsTail) || timeoutHit);
        errCnt_d = errCnt_q;
        if (errEvent && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            errCnt_q <= 8'd0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign ERR_CNT = errCnt_q;
`else
    assign ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_ts_readout_arbiter.sv
// Directed scoreboard bench for ts_readout_arbiter: source FIFOs modelled as queues, output words checked in order.
module tb_ts_readout_arbiter;

`ifdef TS_ARB_ERR_CNT_EN
    localparam logic [31:0] ErrOne = 32'd1;
`else
    localparam logic [31:0] ErrOne = 32'd0;
`endif

    logic        BUS_CLK  = 1'b0;
    logic        RST      = 1'b1;
    logic        in0Empty = 1'b1;
    logic        in1Empty = 1'b1;
    logic [31:0] in0Data  = 32'd0;
    logic [31:0] in1Data  = 32'd0;
    logic        outRead  = 1'b0;
    logic        IN0_READ;
    logic        IN1_READ;
    logic        OUT_EMPTY;
    logic [31:0] OUT_DATA;
    logic [1:0]  LOCKED;
    logic [7:0]  ERR_CNT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] src0[$];
    logic [31:0] src1[$];
    logic [31:0] expQ[$];
    bit          rd0 = 1'b0;
    bit          rd1 = 1'b0;

    ts_readout_arbiter #(.LOCK_TIMEOUT(4)) dut (
        .BUS_CLK  (BUS_CLK),
        .RST      (RST),
        .IN0_EMPTY(in0Empty),
        .IN0_DATA (in0Data),
        .IN0_READ (IN0_READ),
        .IN1_EMPTY(in1Empty),
        .IN1_DATA (in1Data),
        .IN1_READ (IN1_READ),
        .OUT_READ (outRead),
        .OUT_EMPTY(OUT_EMPTY),
        .OUT_DATA (OUT_DATA),
        .LOCKED   (LOCKED),
        .ERR_CNT  (ERR_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [31:0] word, input bit expectOut);
        if (src == 0) src0.push_back(word);
        else src1.push_back(word);
        if (expectOut) expQ.push_back(word);
    endtask

    task automatic stepCycle();
        @(posedge BUS_CLK);
        #2;
    endtask

    task automatic applyReset();
        stepCycle();
        RST = 1'b1;
        stepCycle();
        stepCycle();
        RST = 1'b0;
    endtask

    task automatic waitForRead(input int src, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge BUS_CLK);
            seen = (src == 0) ? IN0_READ : IN1_READ;
        end
        checkOutput(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge BUS_CLK);
            #1;
            done = (expQ.size() == 0) && (src0.size() == 0) && (src1.size() == 0) && (OUT_EMPTY === 1'b1);
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    // Source FIFO model: consume what the DUT popped at the edge, then present the new head word.
    always @(posedge BUS_CLK) begin
        #1;
        if (rd0 && src0.size() > 0) src0.delete(0);
        if (rd1 && src1.size() > 0) src1.delete(0);
        in0Empty = (src0.size() == 0);
        in1Empty = (src1.size() == 0);
        in0Data  = in0Empty ? 32'd0 : src0[0];
        in1Data  = in1Empty ? 32'd0 : src1[0];
    end

    always @(negedge BUS_CLK) begin
        rd0 = IN0_READ;
        rd1 = IN1_READ;
        checkOutput("singleRead", {31'd0, IN0_READ & IN1_READ}, 32'd0);
        checkOutput("readLegal", {31'd0, (IN0_READ & in0Empty) | (IN1_READ & in1Empty) | (RST & (IN0_READ | IN1_READ))}, 32'd0);
        if (!RST && outRead && !OUT_EMPTY) begin
            checkOutput("wordExpected", {31'd0, expQ.size() != 0}, 32'd1);
            if (expQ.size() != 0) checkOutput("outWord", OUT_DATA, expQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge BUS_CLK);
        @(negedge BUS_CLK);
        checkOutput("rstEmpty", {31'd0, OUT_EMPTY}, 32'd1);
        checkOutput("rstData", OUT_DATA, 32'd0);
        checkOutput("rstLocked", 32'(LOCKED), 32'd0);
        checkOutput("rstErr", 32'(ERR_CNT), 32'd0);
        stepCycle();
        RST = 1'b0;

        // Single head/tail packet from IN0 with free-running downstream
        outRead = 1'b1;
        applyStimulus(0, 32'h11000001, 1'b1);
        applyStimulus(0, 32'h12000002, 1'b1);
        waitForRead(0, "t1Pop");
        @(negedge BUS_CLK);
        checkOutput("t1Locked", 32'(LOCKED), 32'd1);
        checkOutput("t1Head", {31'd0, OUT_EMPTY}, 32'd0);
        @(negedge BUS_CLK);
        checkOutput("t1Unlocked", 32'(LOCKED), 32'd0);
        checkOutput("t1Tail", {31'd0, OUT_EMPTY}, 32'd0);
        drain("t1Drain");
        checkOutput("t1Err", 32'(ERR_CNT), 32'd0);

        // Two packets competing: no interleaving, IN0 first after reset
        applyReset();
        applyStimulus(0, 32'h11000011, 1'b1);
        applyStimulus(0, 32'h12000012, 1'b1);
        applyStimulus(1, 32'h21000021, 1'b1);
        applyStimulus(1, 32'h22000022, 1'b1);
        drain("t2Drain");

        // Round-robin alternation on plain words, IN1 served last
        applyStimulus(0, 32'h03000093, 1'b1);
        applyStimulus(1, 32'h03000094, 1'b1);
        applyStimulus(0, 32'h03000095, 1'b1);
        applyStimulus(1, 32'h03000096, 1'b1);
        drain("t2bDrain");
        checkOutput("t2Err", 32'(ERR_CNT), 32'd0);

        // Lock timeout on an emptied IN0 while IN1 waits
        applyReset();
        applyStimulus(0, 32'h11AAAAAA, 1'b1);
        applyStimulus(1, 32'h23BBBBBB, 1'b1);
        waitForRead(0, "t3Pop");
        for (int i = 0; i < 4; i++) begin
            @(negedge BUS_CLK);
            checkOutput("t3NoRead1", {31'd0, IN1_READ}, 32'd0);
            checkOutput("t3Locked", 32'(LOCKED), 32'd1);
        end
        @(negedge BUS_CLK);
        checkOutput("t3Read1", {31'd0, IN1_READ}, 32'd1);
        checkOutput("t3Unlocked", 32'(LOCKED), 32'd0);
        drain("t3Drain");
        checkOutput("t3Err", 32'(ERR_CNT), ErrOne);

        // Stalled output with both sources full
        applyReset();
        outRead = 1'b0;
        applyStimulus(0, 32'h11000031, 1'b1);
        applyStimulus(0, 32'h12000032, 1'b1);
        applyStimulus(1, 32'h23000041, 1'b1);
        waitForRead(0, "t4Pop");
        for (int i = 0; i < 20; i++) begin
            @(negedge BUS_CLK);
            checkOutput("t4NoRead0", {31'd0, IN0_READ}, 32'd0);
            checkOutput("t4NoRead1", {31'd0, IN1_READ}, 32'd0);
            checkOutput("t4Locked", 32'(LOCKED), 32'd1);
            checkOutput("t4Stable", OUT_DATA, 32'h11000031);
        end
        stepCycle();
        outRead = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge BUS_CLK);
            checkOutput("t4Stream", {31'd0, OUT_EMPTY}, 32'd0);
        end
        drain("t4Drain");
        checkOutput("t4Err", 32'(ERR_CNT), 32'd0);

        // Stall with the locked source empty must not age the lock
        applyReset();
        outRead = 1'b0;
        applyStimulus(0, 32'h11000051, 1'b1);
        applyStimulus(1, 32'h23000061, 1'b1);
        waitForRead(0, "t4bPop");
        for (int i = 0; i < 10; i++) begin
            @(negedge BUS_CLK);
            checkOutput("t4bNoRead1", {31'd0, IN1_READ}, 32'd0);
            checkOutput("t4bLocked", 32'(LOCKED), 32'd1);
        end
        stepCycle();
        outRead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge BUS_CLK);
            checkOutput("t4bHold", {31'd0, IN1_READ}, 32'd0);
        end
        @(negedge BUS_CLK);
        checkOutput("t4bRead1", {31'd0, IN1_READ}, 32'd1);
        drain("t4bDrain");
        checkOutput("t4bErr", 32'(ERR_CNT), ErrOne);

        // Orphan head inside a locked packet
        applyReset();
        applyStimulus(0, 32'h11000001, 1'b1);
        applyStimulus(0, 32'h11000002, 1'b1);
        applyStimulus(0, 32'h12000003, 1'b1);
        drain("t5Drain");
        checkOutput("t5Err", 32'(ERR_CNT), ErrOne);
        checkOutput("t5Unlocked", 32'(LOCKED), 32'd0);

        // Reset between head and tail discards the held head and the lock
        outRead = 1'b0;
        applyStimulus(0, 32'h11000071, 1'b0);
        applyStimulus(0, 32'h12000072, 1'b1);
        waitForRead(0, "t6Pop");
        stepCycle();
        @(negedge BUS_CLK);
        checkOutput("t6Locked", 32'(LOCKED), 32'd1);
        checkOutput("t6Stalled", {31'd0, IN0_READ}, 32'd0);
        stepCycle();
        RST = 1'b1;
        outRead = 1'b1;
        @(negedge BUS_CLK);
        checkOutput("t6RstGate", {31'd0, IN0_READ}, 32'd0);
        stepCycle();
        RST = 1'b0;
        outRead = 1'b0;
        @(negedge BUS_CLK);
        checkOutput("t6Empty", {31'd0, OUT_EMPTY}, 32'd1);
        checkOutput("t6Unlocked", 32'(LOCKED), 32'd0);
        checkOutput("t6ErrClr", 32'(ERR_CNT), 32'd0);
        checkOutput("t6TailPop", {31'd0, IN0_READ}, 32'd1);
        stepCycle();
        outRead = 1'b1;
        drain("t6Drain");
        checkOutput("t6Err", 32'(ERR_CNT), 32'd0);
        checkOutput("t6Idle", 32'(LOCKED), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
